// File: rtl/tri_wave_rom.sv
// One period of a symmetric triangular waveform with a synchronous read port.
// Define TRI_WAVE_ROM_INIT_FILE_EN to expose the INIT_FILE parameter of the file-initialised build.
module tri_wave_rom #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8,
   parameter int OUTPUT_REG = 0
`ifdef TRI_WAVE_ROM_INIT_FILE_EN
   ,
   parameter string INIT_FILE = "triangular_1024.dat"
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int SHIFT = ADDR_WIDTH - 1 - DATA_WIDTH;

   if (ADDR_WIDTH < DATA_WIDTH + 1) begin : g_bad_width
      $error("tri_wave_rom: ADDR_WIDTH must be at least DATA_WIDTH+1");
   end

   if (OUTPUT_REG != 0 && OUTPUT_REG != 1) begin : g_bad_output_reg
      $error("tri_wave_rom: OUTPUT_REG must be 0 or 1");
   end

   logic [DATA_WIDTH-1:0] rom [DEPTH];
   logic [DATA_WIDTH-1:0] romQ;

   // Upper half mirrors the lower half: bit-inverting the address gives N-1-a.
   function automatic logic [DATA_WIDTH-1:0] triSample(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] folded;
      logic [ADDR_WIDTH-1:0] scaled;
      folded = a[ADDR_WIDTH-1] ? ~a : a;
      scaled = folded >> SHIFT;
      return scaled[DATA_WIDTH-1:0];
   endfunction

   // Fill the ROM table with one full waveform period at elaboration.
   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom[i] = triSample(ADDR_WIDTH'(i));
   end

   // First read stage: registered lookup, cleared while reset is asserted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         romQ <= '0;
      end else begin
         romQ <= rom[addr];
      end
   end

   if (OUTPUT_REG == 1) begin : g_out_reg
      logic [DATA_WIDTH-1:0] outQ;

      // Optional second pipeline stage for two-cycle latency.
      always_ff @(posedge clk) begin
         if (!rst) begin
            outQ <= '0;
         end else begin
            outQ <= romQ;
         end
      end

      assign rd_data = outQ;
   end else begin : g_no_out_reg
      assign rd_data = romQ;
   end

endmodule

// File: tb/tb_tri_wave_rom.sv
// Randomized and directed checks of both latency variants against an arithmetic waveform model.
module tb_tri_wave_rom;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 8;
    localparam int N          = 1 << ADDR_WIDTH;
    localparam int S          = ADDR_WIDTH - 1 - DATA_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [ADDR_WIDTH-1:0] addr = '0;
    logic [DATA_WIDTH-1:0] rd_data0;
    logic [DATA_WIDTH-1:0] rd_data1;

    int tests_run = 0;
    int tests_failed = 0;

    // Most recent edge at index 0.
    int hist_addr[$];
    bit hist_rst[$];

    tri_wave_rom #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .OUTPUT_REG(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .rd_data (rd_data0)
    );

    tri_wave_rom #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .OUTPUT_REG(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .rd_data (rd_data1)
    );

    always #5 clk = ~clk;

    function automatic int ref_sample(int a);
        if (a < N / 2) return a / (1 << S);
        return (N - 1 - a) / (1 << S);
    endfunction

    // Output after `lat` edges is zero if any of those edges saw reset, else the sample addressed lat-1 edges ago.
    function automatic int expected_out(int lat);
        for (int i = 0; i < lat; i++) begin
            if (i >= hist_rst.size() || !hist_rst[i]) return 0;
        end
        return ref_sample(hist_addr[lat-1]);
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (addr %0d)", tag, observed, expected, addr);
        end
    endtask

    task automatic applyStimulus(input int a, input bit r);
        addr = ADDR_WIDTH'(a);
        rst  = r;
        @(posedge clk);
        hist_addr.push_front(a);
        hist_rst.push_front(r);
        if (hist_addr.size() > 4) begin
            void'(hist_addr.pop_back());
            void'(hist_rst.pop_back());
        end
        #1;
        checkOutput("lat1", int'(rd_data0), expected_out(1));
        checkOutput("lat2", int'(rd_data1), expected_out(2));
    endtask

    int pk_addr [10] = '{0, 1, 2, 510, 511, 512, 513, 514, 1022, 1023};
    int pk_val  [10] = '{0, 0, 1, 255, 255, 255, 255, 254, 0,    0};

    initial begin
        int phase;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(int'($urandom_range(N - 1)), 1'b0);
            checkOutput("reset_zero", int'(rd_data0), 0);
        end
        applyStimulus(2, 1'b1);
        checkOutput("first_after_reset", int'(rd_data0), 1);

        for (int a = 0; a < N; a++) applyStimulus(a, 1'b1);

        // Known sample values independent of the model.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(pk_addr[i], 1'b1);
            checkOutput("known_value", int'(rd_data0), pk_val[i]);
        end

        for (int i = 0; i < 50; i++) begin
            phase = int'($urandom_range(N - 1));
            applyStimulus(phase, 1'b1);
            applyStimulus(N - 1 - phase, 1'b1);
        end

        phase = 990;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(phase, 1'b1);
            phase = (phase + 3) % N;
        end

        // Reset in the middle of a sweep, then resume.
        for (int a = 0; a < 600; a++) begin
            applyStimulus(a, (a >= 300 && a < 303) ? 1'b0 : 1'b1);
        end

        for (int i = 0; i < 500; i++) begin
            applyStimulus(int'($urandom_range(N - 1)), ($urandom_range(19) != 0));
        end

        for (int i = 0; i < 5; i++) applyStimulus(700, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
